// File: rtl/dbus_arbiter.sv
// Two-master round-robin req/ack arbiter for the data-side bus into the Bridge.
// Optional DBUS_LOCK_EN macro enables bounded back-to-back (locked) ownership.
module dbus_arbiter #(
  parameter logic        RR_INIT  = 1'b0,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_byteen_i,
  input  logic        m0_lock_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_byteen_i,
  input  logic        m1_lock_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_byteen_o,
  output logic        bus_we_o,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rr_next_q, rr_next_d;
  logic [AW-1:0]  bus_addr_q, bus_addr_d;
  logic [DW-1:0]  bus_wdata_q, bus_wdata_d;
  logic [BEW-1:0] bus_byteen_q, bus_byteen_d;
  logic           bus_we_q, bus_we_d;
  logic           m0_ack_q, m0_ack_d;
  logic           m1_ack_q, m1_ack_d;
  logic [DW-1:0]  m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]  m1_rdata_q, m1_rdata_d;
  logic           win_c;
  logic           win_locked_c;

`ifdef DBUS_LOCK_EN
  logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic           lock_seen_q, lock_seen_d;
  logic           locked_q, locked_d;
`else
  logic [CW-1:0]  unused_max_c;
  logic           unused_lock_c;
  assign unused_max_c  = CW'(MAX_LOCK);
  assign unused_lock_c = m0_lock_i ^ m1_lock_i;
`endif

  // Winner selection: a locked re-grant to the last owner beats round-robin
  always_comb begin
    win_locked_c = 1'b0;
`ifdef DBUS_LOCK_EN
    win_locked_c = lock_seen_q && (owner_q ? m1_req_i : m0_req_i) &&
                   (lock_cnt_q < CW'(MAX_LOCK));
`endif
    if (win_locked_c) begin
      win_c = owner_q;
    end else if (m0_req_i && m1_req_i) begin
      win_c = rr_next_q;
    end else begin
      win_c = m1_req_i;
    end
  end

  // Next-state: bus fields are only non-zero for the single GRANT cycle
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_next_d    = rr_next_q;
    bus_addr_d   = '0;
    bus_wdata_d  = '0;
    bus_byteen_d = '0;
    bus_we_d     = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
`ifdef DBUS_LOCK_EN
    lock_cnt_d   = lock_cnt_q;
    lock_seen_d  = lock_seen_q;
    locked_d     = locked_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d      = GRANT;
          owner_d      = win_c;
          bus_addr_d   = win_c ? m1_addr_i  : m0_addr_i;
          bus_wdata_d  = win_c ? m1_wdata_i : m0_wdata_i;
          bus_we_d     = win_c ? m1_we_i    : m0_we_i;
          bus_byteen_d = win_c ? (m1_we_i ? m1_byteen_i : '0)
                               : (m0_we_i ? m0_byteen_i : '0);
`ifdef DBUS_LOCK_EN
          locked_d     = win_locked_c;
          lock_cnt_d   = win_locked_c ? (lock_cnt_q + CW'(1)) : '0;
`endif
        end
      end
      GRANT: begin
        state_d    = RESP;
        m0_ack_d   = ~owner_q;
        m1_ack_d   = owner_q;
        m0_rdata_d = owner_q ? '0 : bus_rdata_i;
        m1_rdata_d = owner_q ? bus_rdata_i : '0;
`ifdef DBUS_LOCK_EN
        rr_next_d   = locked_q ? rr_next_q : ~owner_q;
        lock_seen_d = owner_q ? m1_lock_i : m0_lock_i;
`else
        rr_next_d   = ~owner_q;
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= RR_INIT;
      rr_next_q    <= RR_INIT;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_byteen_q <= '0;
      bus_we_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
`ifdef DBUS_LOCK_EN
      lock_cnt_q   <= '0;
      lock_seen_q  <= 1'b0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_next_q    <= rr_next_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_byteen_q <= bus_byteen_d;
      bus_we_q     <= bus_we_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
`ifdef DBUS_LOCK_EN
      lock_cnt_q   <= lock_cnt_d;
      lock_seen_q  <= lock_seen_d;
      locked_q     <= locked_d;
`endif
    end
  end

  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign bus_byteen_o = bus_byteen_q;
  assign bus_we_o     = bus_we_q;
  assign m0_ack_o     = m0_ack_q;
  assign m1_ack_o     = m1_ack_q;
  assign m0_rdata_o   = m0_rdata_q;
  assign m1_rdata_o   = m1_rdata_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios then random traffic, checked against a
// transaction-level arbitration model (locked grants modelled when DBUS_LOCK_EN is set).
module tb_dbus_arbiter;

  localparam int unsigned MAXL = 2;
`ifdef DBUS_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req     [2];
  logic        we      [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic        lock    [2];
  logic        persist [2];
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        m0_ack, m1_ack, bus_we;
  logic [3:0]  bus_byteen;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          slot;
  bit          rr, last_owner, last_lock, g_owner, g_we;
  int          run;
  logic [31:0] g_addr;
  int          order [$];
  int          we_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C);
  endfunction

  assign bus_rdata = rd_fn(bus_addr);

  dbus_arbiter #(.RR_INIT(1'b0), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_byteen_i(be[0]), .m0_lock_i(lock[0]), .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_byteen_i(be[1]), .m1_lock_i(lock[1]), .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_byteen_o(bus_byteen),
    .bus_we_o(bus_we), .bus_rdata_i(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_masters();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      be[i] = '0; lock[i] = 1'b0; persist[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    slot = 0; rr = 1'b0; last_owner = 1'b0; last_lock = 1'b0; run = 0;
  endtask

  task automatic set_master(input int i, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input logic l);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b; lock[i] = l;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    clear_masters();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: predict from pre-edge requests, compare after the edge, retire acked requests
  task automatic step();
    logic        pr [2];
    logic        pw [2];
    logic        pl [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0]  pb [2];
    logic        e_ack [2];
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    bit          w, lk;
    for (int i = 0; i < 2; i++) begin
      pr[i] = req[i]; pw[i] = we[i]; pl[i] = lock[i];
      pa[i] = addr[i]; pd[i] = wdata[i]; pb[i] = be[i];
      e_ack[i] = 1'b0;
    end
    e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
    @(posedge clk);
    #1;
    if (slot == 0) begin
      if (pr[0] || pr[1]) begin
        lk = LOCK_ON && last_lock && pr[last_owner] && (run < int'(MAXL));
        if (lk) begin
          w = last_owner;
          run++;
        end else begin
          w = (pr[0] && pr[1]) ? rr : pr[1];
          run = 0;
          rr = !w;
        end
        last_owner = w; g_owner = w; g_we = pw[w]; g_addr = pa[w];
        order.push_back(int'(w));
        e_addr = pa[w]; e_wdata = pd[w]; e_we = pw[w]; e_be = pw[w] ? pb[w] : 4'h0;
        slot = 1;
      end
    end else if (slot == 1) begin
      e_ack[g_owner] = 1'b1;
      last_lock = pl[g_owner];
      slot = 2;
    end else begin
      slot = 0;
    end
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("bus_byteen", 32'(bus_byteen), 32'(e_be));
    chk("bus_we", 32'(bus_we), 32'(e_we));
    chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
    if (slot == 2) begin
      if (!g_we) chk("owner_rdata", g_owner ? m1_rdata : m0_rdata, rd_fn(g_addr));
      chk("other_rdata", g_owner ? m0_rdata : m1_rdata, 32'h0);
    end
    for (int i = 0; i < 2; i++)
      if (e_ack[i] && !persist[i]) req[i] = 1'b0;
  endtask

  task automatic rand_issue();
    for (int i = 0; i < 2; i++) begin
      if (!req[i] && ($urandom_range(1, 0) == 1)) begin
        req[i]   = 1'b1;
        we[i]    = 1'($urandom_range(1, 0));
        addr[i]  = ($urandom_range(1, 0) == 1) ? (32'h7F00 + 32'($urandom_range(47, 0)))
                                               : 32'($urandom);
        wdata[i] = 32'($urandom);
        be[i]    = 4'($urandom_range(15, 0));
        lock[i]  = ($urandom_range(3, 0) != 0);
      end
    end
  endtask

  initial begin
    int exp_t5 [4];
    reset = 1'b0;
    clear_masters();
    model_reset();
    #12;
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // T1: asynchronous reset in the middle of a GRANT cycle
    set_master(0, 1'b1, 32'h0000_7F04, 32'h0000_1234, 4'hF, 1'b0);
    step();
    reset = 1'b0;
    clear_masters();
    model_reset();
    #2;
    chk("t1_bus_we", 32'(bus_we), 32'h0);
    chk("t1_bus_addr", bus_addr, 32'h0);
    chk("t1_bus_byteen", 32'(bus_byteen), 32'h0);
    chk("t1_acks", 32'({m0_ack, m1_ack}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();

    // T2: single read by the CPU
    set_master(0, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b0);
    step();
    chk("t2_byteen", 32'(bus_byteen), 32'h0);
    step();
    chk("t2_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t2_m1_ack", 32'(m1_ack), 32'h0);
    step();

    // T3: DMA write to DEV1 occupies exactly one bus-write cycle
    set_master(1, 1'b1, 32'h0000_7F14, 32'h0000_00FF, 4'hF, 1'b0);
    we_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      we_cnt += int'(bus_we);
    end
    chk("t3_we_cycles", 32'(we_cnt), 32'd1);

    // T4: continuous contention alternates strictly
    reset_dut();
    set_master(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    set_master(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
    persist[0] = 1'b1; persist[1] = 1'b1;
    order.delete();
    repeat (12) step();
    chk("t4_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("t4_order", 32'(order[k]), 32'(k % 2));
    clear_masters();

    // T5: CPU holding lock against a requesting DMA
    reset_dut();
    set_master(0, 1'b0, 32'h0000_7F20, 32'h0, 4'h0, 1'b1);
    set_master(1, 1'b0, 32'h0000_7F00, 32'h0, 4'h0, 1'b0);
    persist[0] = 1'b1; persist[1] = 1'b1;
    order.delete();
`ifdef DBUS_LOCK_EN
    exp_t5 = '{0, 0, 0, 1};
`else
    exp_t5 = '{0, 1, 0, 1};
`endif
    repeat (12) step();
    chk("t5_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("t5_order", 32'(order[k]), 32'(exp_t5[k]));
    clear_masters();

    // Random traffic against the model
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      rand_issue();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
